// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared constants for the load/store controller: data width, request size
// encodings and FSM state encodings.
package lsu_mem_ctrl_pkg;

    localparam int CPU_WIDTH = 32;

    // req_size encodings
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RD   = 2'b01;
    localparam logic [1:0] ST_WR   = 2'b10;
    localparam logic [1:0] ST_RESP = 2'b11;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store controller.
// Loads: select the lane(s) addressed by addr_lo (little-endian) and
// sign- or zero-extend. Stores: merge the right-aligned store data into
// the addressed lane(s) of the word read from memory.
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [CPU_WIDTH-1:0] word,
    input  logic [1:0]           addr_lo,
    input  logic [1:0]           size,
    input  logic                 is_unsigned,
    input  logic [CPU_WIDTH-1:0] wdata,
    output logic [CPU_WIDTH-1:0] load_data,
    output logic [CPU_WIDTH-1:0] merged
);

    function automatic logic [CPU_WIDTH-1:0] extend8(input logic [7:0] b, input logic zext);
        logic signed [7:0]           sb;
        logic signed [CPU_WIDTH-1:0] sx;
        sb = signed'(b);
        sx = CPU_WIDTH'(sb);
        return zext ? {{(CPU_WIDTH-8){1'b0}}, b} : sx;
    endfunction

    function automatic logic [CPU_WIDTH-1:0] extend16(input logic [15:0] h, input logic zext);
        logic signed [15:0]          sh;
        logic signed [CPU_WIDTH-1:0] sx;
        sh = signed'(h);
        sx = CPU_WIDTH'(sh);
        return zext ? {{(CPU_WIDTH-16){1'b0}}, h} : sx;
    endfunction

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane extraction and store merge; word-sized (and any other size) pass through.
    always_comb begin
        lane_b    = word[{addr_lo, 3'b000} +: 8];
        lane_h    = word[{addr_lo[1], 4'b0000} +: 16];
        load_data = word;
        merged    = wdata;
        case (size)
            SIZE_B: begin
                load_data = extend8(lane_b, is_unsigned);
                merged    = word;
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                load_data = extend16(lane_h, is_unsigned);
                merged    = word;
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller driving a single-port, word-wide data memory.
// Sub-word stores are done as read-modify-write. One request in flight.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned or size-11
// requests complete with resp_err and no memory access; when undefined,
// low address bits are forced to alignment, size 11 acts as word, and
// resp_err is always 0.
module lsu_mem_ctrl #(
    parameter int CPU_WIDTH = lsu_mem_ctrl_pkg::CPU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wen,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [CPU_WIDTH-1:0] req_addr,
    input  logic [CPU_WIDTH-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [CPU_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 mem_wen,
    output logic                 mem_ren,
    output logic [CPU_WIDTH-1:0] mem_addr,
    output logic [CPU_WIDTH-1:0] mem_wdata,
    input  logic [CPU_WIDTH-1:0] mem_rdata
);

    import lsu_mem_ctrl_pkg::*;

    logic [1:0]           state;
    logic [CPU_WIDTH-1:0] addr_q;
    logic [CPU_WIDTH-1:0] wdata_q;
    logic [CPU_WIDTH-1:0] word_q;
    logic [CPU_WIDTH-1:0] rdata_q;
    logic [1:0]           size_q;
    logic                 unsigned_q;
    logic                 wen_q;
    logic                 err_q;

    logic                 accept;
    logic                 misaligned;
    logic [1:0]           eff_size;
    logic [CPU_WIDTH-1:0] eff_addr;
    logic [CPU_WIDTH-1:0] load_data;
    logic [CPU_WIDTH-1:0] merged;

    assign accept = req_valid && (state == ST_IDLE);

    // Classify the incoming request: alignment check or alignment forcing.
    always_comb begin
        eff_size   = req_size;
        eff_addr   = req_addr;
        misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_size)
            SIZE_H:  misaligned = req_addr[0];
            SIZE_W:  misaligned = |req_addr[1:0];
            SIZE_X:  misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
`else
        if (req_size == SIZE_X) eff_size = SIZE_W;
        case (eff_size)
            SIZE_H:  eff_addr[0]   = 1'b0;
            SIZE_W:  eff_addr[1:0] = 2'b00;
            default: eff_addr      = req_addr;
        endcase
`endif
    end

    lsu_lane_align u_lane_align (
        .word        (mem_rdata),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    // FSM and request/data registers; reset clears everything so an aborted
    // store can never reach the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
            size_q     <= SIZE_B;
            unsigned_q <= 1'b0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q     <= eff_addr;
                        wdata_q    <= req_wdata;
                        word_q     <= req_wdata;
                        size_q     <= eff_size;
                        unsigned_q <= req_unsigned;
                        wen_q      <= req_wen;
                        rdata_q    <= '0;
                        err_q      <= misaligned;
                        if (misaligned)
                            state <= ST_RESP;
                        else if (req_wen && (eff_size == SIZE_W))
                            state <= ST_WR;
                        else
                            state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (wen_q) begin
                        word_q <= merged;
                        state  <= ST_WR;
                    end else begin
                        rdata_q <= load_data;
                        state   <= ST_RESP;
                    end
                end
                ST_WR:   state <= ST_RESP;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign mem_ren    = (state == ST_RD);
    assign mem_wen    = (state == ST_WR);
    assign resp_valid = (state == ST_RESP);
    assign mem_addr   = {addr_q[CPU_WIDTH-1:2], 2'b00};
    assign mem_wdata  = word_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed test-plan steps followed by
// random requests, checked against an arithmetic reference of the memory.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    int          total;
    int          bad;
    int          wen_seen;

    lsu_mem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_wen      (mem_wen),
        .mem_ren      (mem_ren),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, synchronous full-word write.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wen_seen <= wen_seen + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and check its whole transaction against the reference.
    task automatic run_req(input logic wen, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] got_rdata, output logic got_err);
        int          n;
        int          sh;
        logic        misal;
        logic        exp_err;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] lane;
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
        int          exp_lat;
        int          exp_ren;
        int          exp_wen;
        int          cycles;
        int          ren_cnt;
        int          wen_cnt;
        int          busy_ready;
        logic        got;
        logic [31:0] wr_word;
        logic [31:0] wr_addr;
        logic [31:0] rd_addr;

        // Reference: plain arithmetic on the access size and byte offset.
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        misal = (size == 2'd3) || ((addr % n) != 0);
        a     = addr;
`ifdef LSU_MISALIGN_TRAP_EN
        exp_err = misal;
`else
        exp_err = 1'b0;
        a = addr & ~(32'(n) - 32'd1);
`endif
        w    = ref_mem[a[7:2]];
        sh   = 8 * int'(a % 4);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        exp_rdata = 32'd0;
        exp_word  = w;
        if (!exp_err && !wen) begin
            lane = (w >> sh) & mask;
            if (!uns && n < 4 && lane[8 * n - 1]) lane = lane | ~mask;
            exp_rdata = lane;
        end
        if (!exp_err && wen) begin
            exp_word = (w & ~(mask << sh)) | ((wdata & mask) << sh);
            ref_mem[a[7:2]] = exp_word;
        end
        exp_lat = exp_err ? 1 : (wen && n < 4) ? 3 : 2;
        exp_ren = (!exp_err && (!wen || n < 4)) ? 1 : 0;
        exp_wen = (!exp_err && wen) ? 1 : 0;

        @(negedge clk);
        chk("ready_before", {31'd0, req_ready}, 32'd1);
        req_wen      = wen;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;

        cycles = 0; ren_cnt = 0; wen_cnt = 0; busy_ready = 0; got = 1'b0;
        wr_word = 32'd0; wr_addr = a & ~32'd3; rd_addr = a & ~32'd3;
        got_rdata = 32'd0; got_err = 1'b0;
        while (!got && cycles < 8) begin
            cycles++;
            if (req_ready) busy_ready++;
            if (mem_ren) begin ren_cnt++; rd_addr = mem_addr; end
            if (mem_wen) begin wen_cnt++; wr_word = mem_wdata; wr_addr = mem_addr; end
            if (resp_valid) begin
                got = 1'b1;
                got_rdata = resp_rdata;
                got_err = resp_err;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("resp_seen", {31'd0, got}, 32'd1);
        chk("latency", 32'(cycles), 32'(exp_lat));
        chk("resp_err", {31'd0, got_err}, {31'd0, exp_err});
        chk("resp_rdata", got_rdata, exp_rdata);
        chk("ren_count", 32'(ren_cnt), 32'(exp_ren));
        chk("wen_count", 32'(wen_cnt), 32'(exp_wen));
        chk("ready_busy", 32'(busy_ready), 32'd0);
        if (exp_ren != 0) chk("rd_addr", rd_addr, a & ~32'd3);
        if (exp_wen != 0) begin
            chk("wr_addr", wr_addr, a & ~32'd3);
            chk("wr_word", wr_word, exp_word);
        end

        @(posedge clk);
        #1;
        chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
        chk("ready_after", {31'd0, req_ready}, 32'd1);
        chk("rdata_hold", resp_rdata, exp_rdata);
        chk("mem_word", mem[a[7:2]], ref_mem[a[7:2]]);
    endtask

    logic [31:0] r;
    logic        e;
    int          wen_before;

    initial begin
        total = 0; bad = 0; wen_seen = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899_AABB;
        ref_mem[4] = 32'h8899_AABB;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_mem_ren", {31'd0, mem_ren}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, r, e);
        chk("lb_11", r, 32'hFFFF_FFAA);
        run_req(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, r, e);
        chk("lbu_11", r, 32'h0000_00AA);
        run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, r, e);
        chk("lh_12", r, 32'hFFFF_8899);
        run_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, r, e);
        chk("lhu_12", r, 32'h0000_8899);
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, r, e);
        chk("lw_10", r, 32'h8899_AABB);
        run_req(1'b0, 2'd2, 1'b0, 32'h12, 32'd0, r, e);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_12_err", {31'd0, e}, 32'd1);
        chk("lw_12_rdata", r, 32'd0);
`else
        chk("lw_12_err", {31'd0, e}, 32'd0);
        chk("lw_12_rdata", r, 32'h8899_AABB);
`endif
        run_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h1234_5655, r, e);
        chk("sb_13_rdata", r, 32'd0);
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, r, e);
        chk("lw_after_sb", r, 32'h5599_AABB);
        run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, r, e);
        chk("sw_mem", mem[4], 32'h1234_5678);

        // Reset during the read phase of a halfword store.
        @(negedge clk);
        req_wen = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0000_CAFE; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("abort_in_rd", {31'd0, mem_ren}, 32'd1);
        wen_before = wen_seen;
        rst_n = 1'b0;
        #1;
        chk("abort_wen", {31'd0, mem_wen}, 32'd0);
        chk("abort_ren", {31'd0, mem_ren}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_wdata", mem_wdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_no_write", 32'(wen_seen - wen_before), 32'd0);
        chk("abort_mem", mem[4], 32'h1234_5678);
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, r, e);
        chk("abort_readback", r, 32'h1234_5678);

        for (int i = 0; i < 60; i++) begin
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 255)), $urandom, r, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
